// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared constants and lane-slice helper for lane_pipe_reg
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int          DEF_LANES = 2;
  localparam int          DEF_WIDTH = 32;
  localparam logic [31:0] NOP_INSN  = 32'h0000_0000;

  // Lane i of a packed multi-lane bus lives at [lane_lsb(i, W) +: W].
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_lane.sv
// ============================================================================
// pipe_lane : one issue slot of the decode/execute pipeline register
// Revision  : 1.0
// ============================================================================
`default_nettype none

module pipe_lane
  import pipe_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] NOP   = WIDTH'(NOP_INSN)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             we_i,
  input  logic             kill_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] insn_i,
  input  logic             bp_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] insn_o,
  output logic             bp_o
);

  logic             valid_q, valid_d;
  logic             bp_q,    bp_d;
  logic [WIDTH-1:0] pc_q,    pc_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] insn_q,  insn_d;
  logic             w_live;

  assign w_live = valid_i & ~kill_i;

  always_comb begin
    valid_d = valid_q;
    bp_d    = bp_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    insn_d  = insn_q;
    if (flush_i) begin
      valid_d = 1'b0;
      bp_d    = 1'b0;
      pc_d    = '0;
      a_d     = '0;
      b_d     = '0;
      insn_d  = NOP;
    end else if (we_i) begin
      // pc/operands are captured even for dead slots so traces stay meaningful
      valid_d = w_live;
      pc_d    = pc_i;
      a_d     = a_i;
      b_d     = b_i;
      insn_d  = w_live ? insn_i : NOP;
      bp_d    = w_live & bp_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      bp_q    <= 1'b0;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      insn_q  <= NOP;
    end else begin
      valid_q <= valid_d;
      bp_q    <= bp_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      insn_q  <= insn_d;
    end
  end

  assign valid_o = valid_q;
  assign bp_o    = bp_q;
  assign pc_o    = pc_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign insn_o  = insn_q;

endmodule

`default_nettype wire

// File: rtl/lane_pipe_reg.sv
// ============================================================================
// lane_pipe_reg : multi-lane decode/execute pipeline register with
//                 stall, flush, per-lane kill and saturating perf counters
// Revision      : 1.0
// ============================================================================
`default_nettype none

module lane_pipe_reg
  import pipe_pkg::*;
#(
  parameter int               LANES = DEF_LANES,
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] NOP   = WIDTH'(NOP_INSN),
  parameter int               CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic                   flush,
  input  logic [LANES-1:0]       kill_mask,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] pc_in,
  input  logic [LANES*WIDTH-1:0] data_inA,
  input  logic [LANES*WIDTH-1:0] data_inB,
  input  logic [LANES*WIDTH-1:0] instruction_in,
  input  logic [LANES-1:0]       bp_taken_in,
  output logic [LANES-1:0]       valid_out,
  output logic [LANES*WIDTH-1:0] pc_out,
  output logic [LANES*WIDTH-1:0] data_outA,
  output logic [LANES*WIDTH-1:0] data_outB,
  output logic [LANES*WIDTH-1:0] instruction_out,
  output logic [LANES-1:0]       bp_taken_out,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int LSB = lane_lsb(gi, WIDTH);

    pipe_lane #(
      .WIDTH (WIDTH),
      .NOP   (NOP)
    ) u_lane (
      .clk_i   (clk),
      .rst_ni  (reset),
      .flush_i (flush),
      .we_i    (we),
      .kill_i  (kill_mask[gi]),
      .valid_i (in_valid[gi]),
      .pc_i    (pc_in[LSB +: WIDTH]),
      .a_i     (data_inA[LSB +: WIDTH]),
      .b_i     (data_inB[LSB +: WIDTH]),
      .insn_i  (instruction_in[LSB +: WIDTH]),
      .bp_i    (bp_taken_in[gi]),
      .valid_o (valid_out[gi]),
      .pc_o    (pc_out[LSB +: WIDTH]),
      .a_o     (data_outA[LSB +: WIDTH]),
      .b_o     (data_outB[LSB +: WIDTH]),
      .insn_o  (instruction_out[LSB +: WIDTH]),
      .bp_o    (bp_taken_out[gi])
    );
  end

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Flush wins over stall, so a flush edge never counts as a stall cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (!we && (|valid_out)) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_lane_pipe_reg.sv
// ============================================================================
// tb_lane_pipe_reg : scoreboard bench for lane_pipe_reg (16-bit and 2-bit counters)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_lane_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, we, flush;
  logic [1:0]  kill_mask, in_valid, bp_taken_in;
  logic [63:0] pc_in, data_inA, data_inB, instruction_in;

  logic [1:0]  valid_out, bp_taken_out;
  logic [63:0] pc_out, data_outA, data_outB, instruction_out;
  logic [15:0] stall_cnt, flush_cnt;

  logic [1:0]  s_valid_out, s_bp_taken_out;
  logic [63:0] s_pc_out, s_data_outA, s_data_outB, s_instruction_out;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  lane_pipe_reg #(.LANES(2), .WIDTH(32), .NOP(32'h0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .we(we), .flush(flush), .kill_mask(kill_mask),
    .in_valid(in_valid), .pc_in(pc_in), .data_inA(data_inA), .data_inB(data_inB),
    .instruction_in(instruction_in), .bp_taken_in(bp_taken_in),
    .valid_out(valid_out), .pc_out(pc_out), .data_outA(data_outA),
    .data_outB(data_outB), .instruction_out(instruction_out),
    .bp_taken_out(bp_taken_out), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  lane_pipe_reg #(.LANES(2), .WIDTH(32), .NOP(32'h0), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .we(we), .flush(flush), .kill_mask(kill_mask),
    .in_valid(in_valid), .pc_in(pc_in), .data_inA(data_inA), .data_inB(data_inB),
    .instruction_in(instruction_in), .bp_taken_in(bp_taken_in),
    .valid_out(s_valid_out), .pc_out(s_pc_out), .data_outA(s_data_outA),
    .data_outB(s_data_outB), .instruction_out(s_instruction_out),
    .bp_taken_out(s_bp_taken_out), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct {
    logic [1:0]  v, bp;
    logic [63:0] pc, a, b, ins;
    logic [15:0] sc, fc;
    logic [1:0]  sc2, fc2;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour of one clock edge, applied to the bench's expected state.
  task automatic model_edge(input logic r, w, f, input logic [1:0] k, iv, bpi,
                            input logic [63:0] pci, ai, bi, insi);
    logic live;
    if (!r) begin
      m.v = '0; m.bp = '0; m.pc = '0; m.a = '0; m.b = '0; m.ins = '0;
      m.sc = '0; m.fc = '0; m.sc2 = '0; m.fc2 = '0;
    end else if (f) begin
      m.v = '0; m.bp = '0; m.pc = '0; m.a = '0; m.b = '0; m.ins = '0;
      if (m.fc  != 16'hFFFF) m.fc  = m.fc + 16'd1;
      if (m.fc2 != 2'b11)    m.fc2 = m.fc2 + 2'd1;
    end else if (w) begin
      for (int i = 0; i < 2; i++) begin
        live = iv[i] & ~k[i];
        m.v[i]          = live;
        m.bp[i]         = live & bpi[i];
        m.pc[i*32 +: 32] = pci[i*32 +: 32];
        m.a[i*32 +: 32]  = ai[i*32 +: 32];
        m.b[i*32 +: 32]  = bi[i*32 +: 32];
        m.ins[i*32 +: 32] = live ? insi[i*32 +: 32] : 32'h0;
      end
    end else if (|m.v) begin
      if (m.sc  != 16'hFFFF) m.sc  = m.sc + 16'd1;
      if (m.sc2 != 2'b11)    m.sc2 = m.sc2 + 2'd1;
    end
  endtask

  task automatic step(input logic r, w, f, input logic [1:0] k, iv, bpi,
                      input logic [63:0] pci, ai, bi, insi);
    reset = r; we = w; flush = f; kill_mask = k; in_valid = iv; bp_taken_in = bpi;
    pc_in = pci; data_inA = ai; data_inB = bi; instruction_in = insi;
    @(posedge clk);
    model_edge(r, w, f, k, iv, bpi, pci, ai, bi, insi);
    q.push_back(m);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: every negedge after a pushed edge, compare DUT state against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid_out",       {62'h0, valid_out},    {62'h0, e.v});
        chk("bp_taken_out",    {62'h0, bp_taken_out}, {62'h0, e.bp});
        chk("pc_out",          pc_out,                e.pc);
        chk("data_outA",       data_outA,             e.a);
        chk("data_outB",       data_outB,             e.b);
        chk("instruction_out", instruction_out,       e.ins);
        chk("stall_cnt",       {48'h0, stall_cnt},    {48'h0, e.sc});
        chk("flush_cnt",       {48'h0, flush_cnt},    {48'h0, e.fc});
        chk("sat_stall_cnt",   {62'h0, s_stall_cnt},  {62'h0, e.sc2});
        chk("sat_flush_cnt",   {62'h0, s_flush_cnt},  {62'h0, e.fc2});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [63:0] PC0  = {32'h0000_0104, 32'h0000_0100};
  localparam logic [63:0] A0   = {32'h1111_2222, 32'h3333_4444};
  localparam logic [63:0] B0   = {32'h5555_6666, 32'h7777_8888};
  localparam logic [63:0] INS0 = {32'h0000_AAAA, 32'h0000_5555};

  initial begin
    m = '{default: '0};

    // reset with random inputs
    repeat (2) step(1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                    2'($urandom), rnd64(), rnd64(), rnd64(), rnd64());

    // advance
    step(1'b1, 1'b1, 1'b0, 2'b00, 2'b11, 2'b01, PC0, A0, B0, INS0);

    // stall 3 cycles with changing inputs and kill_mask
    repeat (3) step(1'b1, 1'b0, 1'b0, 2'($urandom), 2'($urandom), 2'($urandom),
                    rnd64(), rnd64(), rnd64(), rnd64());

    // kill lane 1
    step(1'b1, 1'b1, 1'b0, 2'b10, 2'b11, 2'b11, PC0, A0, B0, INS0);
    // kill lane 0, keep lane 1
    step(1'b1, 1'b1, 1'b0, 2'b01, 2'b11, 2'b10,
         {32'h0000_0204, 32'h0000_0200}, B0, A0, {32'hDEAD_BEEF, 32'h1234_5678});
    // invalid lane 1 without kill
    step(1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 2'b11, PC0, A0, B0, INS0);

    // flush over advance
    step(1'b1, 1'b1, 1'b1, 2'b00, 2'b11, 2'b11, PC0, A0, B0, INS0);

    // stall with nothing valid: stall_cnt must not move
    repeat (2) step(1'b1, 1'b0, 1'b0, 2'b00, 2'b11, 2'b11, rnd64(), rnd64(), rnd64(), rnd64());

    // flush while stalled
    step(1'b1, 1'b0, 1'b1, 2'b00, 2'b11, 2'b00, PC0, A0, B0, INS0);

    // reset mid-stream clears counters
    step(1'b0, 1'b1, 1'b0, 2'b00, 2'b11, 2'b11, PC0, A0, B0, INS0);

    // saturation: load then stall 6 cycles (2-bit counter holds at 3)
    step(1'b1, 1'b1, 1'b0, 2'b00, 2'b11, 2'b01, PC0, A0, B0, INS0);
    repeat (6) step(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, rnd64(), rnd64(), rnd64(), rnd64());

    // flush saturation on the 2-bit instance
    repeat (5) step(1'b1, 1'b0, 1'b1, 2'b00, 2'b11, 2'b11, PC0, A0, B0, INS0);

    // reset during stall, then normal operation resumes
    step(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, PC0, A0, B0, INS0);
    step(1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b10, PC0, A0, B0, INS0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lane_pipe_reg.md
# lane_pipe_reg

Parametrised multi-lane pipeline register for the superscalar decode/execute boundary. Carries PC, two operands, instruction word, valid bit and branch-prediction bit for each of LANES issue slots. Supports stall (hold), full flush, and per-lane kill, which turns a killed or invalid lane into a NOP bubble. Saturating stall and flush counters are included for performance monitoring.

## Interface
- LANES, 2, number of issue lanes; lane 0 is the oldest.
- WIDTH, 32, width of PC, operand and instruction fields.
- NOP, 32'h0000_0000, instruction value driven in bubble lanes.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-low; sampled on the clk rising edge.
- we  in  1  advance enable; 0 means stall and hold the contents.
- flush  in  1  kill all lanes on this edge; overrides we.
- kill_mask  in  LANES  per-lane kill, applied only when we=1 and flush=0.
- in_valid  in  LANES  per-lane valid of the incoming slot.
- pc_in, data_inA, data_inB, instruction_in  in  LANES*WIDTH each  lane i occupies bits [i*WIDTH +: WIDTH].
- bp_taken_in  in  LANES  predicted-taken bit per lane.
- valid_out  out  LANES  registered lane valid.
- pc_out, data_outA, data_outB, instruction_out  out  LANES*WIDTH each  registered fields.
- bp_taken_out  out  LANES  registered prediction bit.
- stall_cnt  out  CNT_W  number of cycles held with at least one valid lane.
- flush_cnt  out  CNT_W  number of flush edges.

## Operation
Priority on each rising edge is reset, then flush, then we, then hold.
- **Reset** (reset=0):
  - valid_out=0 and bp_taken_out=0.
  - pc_out, data_outA and data_outB = 0.
  - instruction_out = NOP in every lane.
  - Both counters = 0.
- **Flush** (reset=1, flush=1):
  - Every lane gets valid=0, bp=0 and instruction=NOP.
  - pc, data_outA and data_outB are cleared to 0.
  - flush_cnt increments, saturating at 2^CNT_W-1.
  - we, kill_mask and in_valid are ignored.
- **Advance** (we=1, flush=0), per lane i:
  - live = in_valid[i] & ~kill_mask[i].
  - valid_out[i] <= live.
  - pc and both operands are always captured, including in dead lanes, for trace and debug.
  - If live: instruction_out[i] <= instruction_in[i] and bp_taken_out[i] <= bp_taken_in[i].
  - If not live: instruction_out[i] <= NOP and bp_taken_out[i] <= 0.
- **Hold** (we=0, flush=0):
  - All fields and valid bits keep their values; kill_mask is ignored.
  - stall_cnt increments (saturating) only if |valid_out is 1 before the edge.
- Lanes are independent. There is no ordering check on kill_mask: killing lane 0 while keeping lane 1 is legal.
- Counters saturate and never wrap. They are cleared only by reset.

## Timing
- Latency is 1 cycle from input to output on an advancing edge. There is no combinational path from inputs to outputs.
- A flush asserted in cycle n produces all-invalid outputs in cycle n+1, even if we=0 in cycle n.
- A reset asserted mid-stall or mid-flush takes effect on that same edge. Counters read 0 in the following cycle.
- When flush and we are both asserted, only the flush is performed. flush_cnt increments and stall_cnt does not change.
- When reset is deasserted, the first edge with reset=1 follows the normal priority.

## Structure
- Shared package (`pipe_pkg`):
  - NOP_INSN constant, used as the default for NOP.
  - Default LANES and WIDTH.
  - A lane-field slice helper function.
- One sub-module, `pipe_lane`:
  - Holds a single lane's valid, pc, A, B, instruction and bp registers, with synchronous active-low reset, flush, we and kill inputs.
  - Instantiated LANES times by a generate loop.
- The two saturating counters live in the top level.

## Test plan
- **Reset:** drive reset=0 for 2 cycles with random inputs -> valid_out=0, instruction_out=NOP in all lanes, pc_out=0, and both counters 0.
- **Advance:** LANES=2, we=1, in_valid=2'b11, pc_in={32'h104, 32'h100}, instr={32'hAAAA, 32'h5555}, bp=2'b01 -> next cycle the outputs equal the inputs exactly, and valid_out=2'b11.
- **Stall:**
  - Load the values above, then hold we=0 for 3 cycles while changing the inputs -> outputs unchanged and stall_cnt=3.
  - Repeat with valid_out=0 -> stall_cnt unchanged.
- **Kill:** we=1, in_valid=2'b11, kill_mask=2'b10 -> valid_out=2'b01, lane 1 instruction=NOP and bp=0, lane 1 pc still captured as 32'h104.
- **Flush over advance:** flush=1 and we=1 with valid inputs -> valid_out=0, all instructions NOP, flush_cnt increments by 1, stall_cnt unchanged.
- **Saturation:** CNT_W=2, stall for 6 cycles -> stall_cnt stays at 3. Then reset=0 for one edge -> stall_cnt=0 on the next cycle.
